comparator_2bit_checker: RTL and testbench

- Synthesizable response checker for the 2-bit magnitude comparator. It is the receiving end of the comparator's stimulus/response interface.
- It samples each applied {a,b} vector together with the DUT outputs e, g and l. It compares them against an internal reference, counts mismatches and tracks coverage of all operand pairs.
- It flags done and pass once every vector has been seen. It sits beside the comparator in the BIST/bring-up wrapper, opposite the stimulus sweeper.

---
 rtl/comparator_chk_pkg.sv | 36 +++
 rtl/comparator_ref_model.sv | 19 +
 rtl/comparator_2bit_checker.sv | 177 +++++++++++++++++
 tb/tb_comparator_2bit_checker.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comparator_chk_pkg.sv
// Shared types and helpers for comparator response checkers.
// Holds the checker FSM encoding, the {e,g,l} bit positions and the
// golden compare function used by every reference model.
package comparator_chk_pkg;

    // Checker FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_e;

    // Bit positions inside an {e,g,l} response word.
    localparam int EGL_W = 3;
    localparam int EGL_E = 2;
    localparam int EGL_G = 1;
    localparam int EGL_L = 0;

    // Widest operand the shared compare function accepts. Narrower
    // operands are zero-extended, which keeps an unsigned compare exact.
    localparam int REF_MAX_W = 16;

    // Golden response of an unsigned magnitude comparator.
    function automatic logic [EGL_W-1:0] calc_exp_egl(
        input logic [REF_MAX_W-1:0] op_a,
        input logic [REF_MAX_W-1:0] op_b
    );
        logic [EGL_W-1:0] egl;
        egl        = '0;
        egl[EGL_E] = (op_a == op_b);
        egl[EGL_G] = (op_a >  op_b);
        egl[EGL_L] = (op_a <  op_b);
        return egl;
    endfunction

endpackage : comparator_chk_pkg

// File: rtl/comparator_ref_model.sv
// Combinational reference for a WIDTH-bit unsigned magnitude comparator.
// Produces the expected {e,g,l} word for the operands currently applied.
module comparator_ref_model
    import comparator_chk_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [EGL_W-1:0] exp_egl_o
);

    // Zero-extend into the shared function so one golden model serves
    // every operand width up to REF_MAX_W.
    always_comb begin
        exp_egl_o = calc_exp_egl(REF_MAX_W'(a_i), REF_MAX_W'(b_i));
    end

endmodule : comparator_ref_model

// File: rtl/comparator_2bit_checker.sv
// Response checker for the 2-bit magnitude comparator.
// Samples each valid {a,b} vector with the comparator outputs, compares
// against the reference model, counts samples and mismatches, captures
// the first failing vector and tracks coverage of every operand pair.
// done rises on the edge that covers the last outstanding vector.
module comparator_2bit_checker
    import comparator_chk_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int ERR_W = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               vld,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               e,
    input  logic               g,
    input  logic               l,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_cnt,
    output logic [CNT_W-1:0]   vec_cnt,
    output logic               fail_seen,
    output logic [2*WIDTH-1:0] first_fail_vec,
    output logic [EGL_W-1:0]   first_fail_egl
);

    localparam int VEC_W   = 2 * WIDTH;
    localparam int NUM_VEC = 2 ** VEC_W;

    // ------------------------------------------------------------------
    // State and next-state
    // ------------------------------------------------------------------
    chk_state_e         state_q,      state_d;
    logic [ERR_W-1:0]   err_cnt_q,    err_cnt_d;
    logic [CNT_W-1:0]   vec_cnt_q,    vec_cnt_d;
    logic [NUM_VEC-1:0] cov_q,        cov_d;
    logic               fail_seen_q,  fail_seen_d;
    logic [VEC_W-1:0]   ff_vec_q,     ff_vec_d;
    logic [EGL_W-1:0]   ff_egl_q,     ff_egl_d;

    // ------------------------------------------------------------------
    // Sample decode
    // ------------------------------------------------------------------
    logic [EGL_W-1:0]   exp_egl;
    logic [EGL_W-1:0]   obs_egl;
    logic [VEC_W-1:0]   vec_idx;
    logic [NUM_VEC-1:0] cov_set;
    logic               sample;
    logic               mismatch;
    logic               cov_full;

    comparator_ref_model #(
        .WIDTH     (WIDTH)
    ) u_ref (
        .a_i       (a),
        .b_i       (b),
        .exp_egl_o (exp_egl)
    );

    // Decode the current sample: which vector it is, whether it fails and
    // whether it would complete coverage.
    always_comb begin
        obs_egl  = {e, g, l};
        vec_idx  = {a, b};
        mismatch = (obs_egl != exp_egl);
        // start wins over vld, so a restart cycle never counts a sample.
        sample   = (state_q == RUN) && vld && !start;
        cov_set  = cov_q | (NUM_VEC'(1) << vec_idx);
        cov_full = &cov_set;
    end

    // Next-state logic for the FSM.
    // NOTE: every always_comb output gets a default first so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (sample && cov_full) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Next-state logic for counters, coverage and first-fail capture.
    always_comb begin
        err_cnt_d   = err_cnt_q;
        vec_cnt_d   = vec_cnt_q;
        cov_d       = cov_q;
        fail_seen_d = fail_seen_q;
        ff_vec_d    = ff_vec_q;
        ff_egl_d    = ff_egl_q;

        if (start) begin
            // A start from any state opens a fresh run.
            err_cnt_d   = '0;
            vec_cnt_d   = '0;
            cov_d       = '0;
            fail_seen_d = 1'b0;
            ff_vec_d    = '0;
            ff_egl_d    = '0;
        end else if (sample) begin
            if (vec_cnt_q != {CNT_W{1'b1}}) begin
                vec_cnt_d = vec_cnt_q + CNT_W'(1);
            end
            cov_d = cov_set;
            if (mismatch) begin
                if (err_cnt_q != {ERR_W{1'b1}}) begin
                    err_cnt_d = err_cnt_q + ERR_W'(1);
                end
                // Only the first failure of a run is kept for debug.
                if (!fail_seen_q) begin
                    fail_seen_d = 1'b1;
                    ff_vec_d    = vec_idx;
                    ff_egl_d    = obs_egl;
                end
            end
        end
    end

    // State registers with synchronous active-low reset.
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            err_cnt_q   <= '0;
            vec_cnt_q   <= '0;
            // NOTE: the coverage bitmap is reset explicitly; it is plain
            // flops, not a RAM, and a stale bit would end a sweep early.
            cov_q       <= '0;
            fail_seen_q <= 1'b0;
            ff_vec_q    <= '0;
            ff_egl_q    <= '0;
        end else begin
            state_q     <= state_d;
            err_cnt_q   <= err_cnt_d;
            vec_cnt_q   <= vec_cnt_d;
            cov_q       <= cov_d;
            fail_seen_q <= fail_seen_d;
            ff_vec_q    <= ff_vec_d;
            ff_egl_q    <= ff_egl_d;
        end
    end

    // Outputs are straight decodes of registered state.
    always_comb begin
        busy           = (state_q == RUN);
        done           = (state_q == DONE);
        pass           = (state_q == DONE) && (err_cnt_q == '0);
        err_cnt        = err_cnt_q;
        vec_cnt        = vec_cnt_q;
        fail_seen      = fail_seen_q;
        first_fail_vec = ff_vec_q;
        first_fail_egl = ff_egl_q;
    end

endmodule : comparator_2bit_checker

// File: tb/tb_comparator_2bit_checker.sv
// Scoreboard bench for comparator_2bit_checker.
// The driver applies one directed vector per cycle and queues the result
// the checker must show after the next edge; a monitor on the falling
// edge pops and compares. Two checker instances share the stimulus: one
// with the default 8-bit error counter and one with a 4-bit counter.
module tb_comparator_2bit_checker;

    typedef struct {
        int          due;
        logic        busy;
        logic        done;
        logic        pass;
        logic [7:0]  err;
        logic [3:0]  err4;
        logic [15:0] vec;
        logic        fs;
        logic [3:0]  ffv;
        logic [2:0]  ffe;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        vld;
    logic [1:0]  a;
    logic [1:0]  b;
    logic        e;
    logic        g;
    logic        l;

    logic        busy,  done,  pass,  fail_seen;
    logic [7:0]  err_cnt;
    logic [15:0] vec_cnt;
    logic [3:0]  first_fail_vec;
    logic [2:0]  first_fail_egl;

    logic        busy4, done4, pass4, fail_seen4;
    logic [3:0]  err_cnt4;
    logic [15:0] vec_cnt4;
    logic [3:0]  first_fail_vec4;
    logic [2:0]  first_fail_egl4;

    comparator_2bit_checker #(.WIDTH(2), .ERR_W(8), .CNT_W(16)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .vld            (vld),
        .a              (a),
        .b              (b),
        .e              (e),
        .g              (g),
        .l              (l),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_cnt        (err_cnt),
        .vec_cnt        (vec_cnt),
        .fail_seen      (fail_seen),
        .first_fail_vec (first_fail_vec),
        .first_fail_egl (first_fail_egl)
    );

    comparator_2bit_checker #(.WIDTH(2), .ERR_W(4), .CNT_W(16)) u_dut4 (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .vld            (vld),
        .a              (a),
        .b              (b),
        .e              (e),
        .g              (g),
        .l              (l),
        .busy           (busy4),
        .done           (done4),
        .pass           (pass4),
        .err_cnt        (err_cnt4),
        .vec_cnt        (vec_cnt4),
        .fail_seen      (fail_seen4),
        .first_fail_vec (first_fail_vec4),
        .first_fail_egl (first_fail_egl4)
    );

    // Hand-computed correct {e,g,l} for every {a,b}, index = {a,b}.
    logic [2:0] correct_egl [16] = '{
        3'b100, 3'b001, 3'b001, 3'b001,   // a=0, b=0..3
        3'b010, 3'b100, 3'b001, 3'b001,   // a=1
        3'b010, 3'b010, 3'b100, 3'b001,   // a=2
        3'b010, 3'b010, 3'b010, 3'b100    // a=3
    };

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    exp_t sb_q[$];
    exp_t mon_x;

    // Bench-side model of what the checker should hold.
    int          m_state = 0;   // 0 idle, 1 run, 2 done
    int          m_err   = 0;
    int          m_vec   = 0;
    logic [15:0] m_cov   = '0;
    logic        m_fs    = 1'b0;
    logic [3:0]  m_ffv   = '0;
    logic [2:0]  m_ffe   = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t mk_exp(logic busy_v, logic done_v, logic pass_v, logic [7:0] err_v,
                                    logic [3:0] err4_v, logic [15:0] vec_v, logic fs_v,
                                    logic [3:0] ffv_v, logic [2:0] ffe_v);
        exp_t x;
        x.due  = 0;
        x.busy = busy_v;
        x.done = done_v;
        x.pass = pass_v;
        x.err  = err_v;
        x.err4 = err4_v;
        x.vec  = vec_v;
        x.fs   = fs_v;
        x.ffv  = ffv_v;
        x.ffe  = ffe_v;
        return x;
    endfunction

    function automatic exp_t model_snapshot();
        return mk_exp(m_state == 1, m_state == 2, (m_state == 2) && (m_err == 0),
                      (m_err > 255) ? 8'hFF : 8'(m_err),
                      (m_err > 15) ? 4'hF : 4'(m_err),
                      (m_vec > 65535) ? 16'hFFFF : 16'(m_vec),
                      m_fs, m_ffv, m_ffe);
    endfunction

    task automatic model_clear();
        m_err = 0;
        m_vec = 0;
        m_cov = '0;
        m_fs  = 1'b0;
        m_ffv = '0;
        m_ffe = '0;
    endtask

    task automatic model_step(input logic rst_v, input logic start_v, input logic vld_v,
                              input logic [3:0] ab, input logic [2:0] egl);
        if (!rst_v) begin
            model_clear();
            m_state = 0;
        end else if (start_v) begin
            model_clear();
            m_state = 1;
        end else if (m_state == 1 && vld_v) begin
            m_vec++;
            m_cov[ab] = 1'b1;
            if (egl != correct_egl[ab]) begin
                m_err++;
                if (!m_fs) begin
                    m_fs  = 1'b1;
                    m_ffv = ab;
                    m_ffe = egl;
                end
            end
            if (m_cov == 16'hFFFF) m_state = 2;
        end
    endtask

    // Apply one cycle of stimulus and queue the model's expected result.
    task automatic drive(input logic rst_v, input logic start_v, input logic vld_v,
                         input logic [3:0] ab, input logic [2:0] egl);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n     = rst_v;
        start     = start_v;
        vld       = vld_v;
        a         = ab[3:2];
        b         = ab[1:0];
        {e, g, l} = egl;
        model_step(rst_v, start_v, vld_v, ab, egl);
        x     = model_snapshot();
        x.due = cyc + 1;
        sb_q.push_back(x);
    endtask

    // Idle cycle whose expected result is a hand-written constant.
    task automatic drive_hand(input exp_t hx);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start = 1'b0;
        vld   = 1'b0;
        model_step(1'b1, 1'b0, 1'b0, 4'h0, 3'b000);
        x     = hx;
        x.due = cyc + 1;
        sb_q.push_back(x);
    endtask

    // One pass over all 16 vectors; up to two indices get a forced response.
    task automatic sweep(input int fa, input logic [2:0] fa_egl, input int fb, input logic [2:0] fb_egl);
        for (int i = 0; i < 16; i++) begin
            logic [2:0] egl;
            egl = correct_egl[i];
            if (i == fa) egl = fa_egl;
            if (i == fb) egl = fb_egl;
            drive(1'b1, 1'b0, 1'b1, 4'(i), egl);
        end
    endtask

    // Monitor: compare every queued expectation on its due cycle.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            mon_x = sb_q.pop_front();
            if (mon_x.due != cyc) begin
                check("sb_due", 32'(cyc), 32'(mon_x.due));
            end else begin
                check("busy",           32'(busy),           32'(mon_x.busy));
                check("done",           32'(done),           32'(mon_x.done));
                check("pass",           32'(pass),           32'(mon_x.pass));
                check("err_cnt",        32'(err_cnt),        32'(mon_x.err));
                check("err_cnt_w4",     32'(err_cnt4),       32'(mon_x.err4));
                check("vec_cnt",        32'(vec_cnt),        32'(mon_x.vec));
                check("fail_seen",      32'(fail_seen),      32'(mon_x.fs));
                check("first_fail_vec", 32'(first_fail_vec), 32'(mon_x.ffv));
                check("first_fail_egl", 32'(first_fail_egl), 32'(mon_x.ffe));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        vld   = 1'b0;
        a     = '0;
        b     = '0;
        e     = 1'b0;
        g     = 1'b0;
        l     = 1'b0;

        // Reset state, then a vld in IDLE that must be ignored.
        drive(1'b0, 1'b0, 1'b0, 4'h0, 3'b000);
        drive(1'b0, 1'b0, 1'b0, 4'h0, 3'b000);
        drive(1'b1, 1'b0, 1'b1, 4'h9, 3'b111);
        drive_hand(mk_exp(0, 0, 0, 8'd0, 4'd0, 16'd0, 0, 4'h0, 3'b000));

        // Clean sweep: done one edge after the 16th sample, pass.
        drive(1'b1, 1'b1, 1'b0, 4'h0, 3'b000);
        sweep(-1, 3'b000, -1, 3'b000);
        drive_hand(mk_exp(0, 1, 1, 8'd0, 4'd0, 16'd16, 0, 4'h0, 3'b000));
        // vld in DONE is ignored, even a failing one.
        drive(1'b1, 1'b0, 1'b1, 4'h3, 3'b111);
        drive_hand(mk_exp(0, 1, 1, 8'd0, 4'd0, 16'd16, 0, 4'h0, 3'b000));

        // Fault at {a,b}=1001: 100 instead of 010.
        drive(1'b1, 1'b1, 1'b0, 4'h0, 3'b000);
        sweep(9, 3'b100, -1, 3'b000);
        drive_hand(mk_exp(0, 1, 0, 8'd1, 4'd1, 16'd16, 1, 4'h9, 3'b100));

        // Vectors 0..14 twice, then 15: done only after 15.
        drive(1'b1, 1'b1, 1'b0, 4'h0, 3'b000);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 15; i++) drive(1'b1, 1'b0, 1'b1, 4'(i), correct_egl[i]);
        end
        drive_hand(mk_exp(1, 0, 0, 8'd0, 4'd0, 16'd30, 0, 4'h0, 3'b000));
        drive(1'b1, 1'b0, 1'b1, 4'hF, 3'b100);
        drive_hand(mk_exp(0, 1, 1, 8'd0, 4'd0, 16'd31, 0, 4'h0, 3'b000));

        // Restart with vld after 8 vectors; the start-cycle sample is dropped.
        drive(1'b1, 1'b1, 1'b0, 4'h0, 3'b000);
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b1, 4'(i), correct_egl[i]);
        drive(1'b1, 1'b1, 1'b1, 4'h8, 3'b000);
        drive_hand(mk_exp(1, 0, 0, 8'd0, 4'd0, 16'd0, 0, 4'h0, 3'b000));
        // Two faults: only the first is captured.
        sweep(2, 3'b000, 7, 3'b111);
        drive_hand(mk_exp(0, 1, 0, 8'd2, 4'd2, 16'd16, 1, 4'h2, 3'b000));

        // Reset mid-sweep with two errors logged, then ignored samples.
        drive(1'b1, 1'b1, 1'b0, 4'h0, 3'b000);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 1'b1, 4'(i), (i == 1 || i == 4) ? 3'b000 : correct_egl[i]);
        end
        drive_hand(mk_exp(1, 0, 0, 8'd2, 4'd2, 16'd6, 1, 4'h1, 3'b000));
        drive(1'b0, 1'b0, 1'b1, 4'h6, 3'b000);
        drive_hand(mk_exp(0, 0, 0, 8'd0, 4'd0, 16'd0, 0, 4'h0, 3'b000));
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 1'b1, 4'(i), 3'b000);
        drive_hand(mk_exp(0, 0, 0, 8'd0, 4'd0, 16'd0, 0, 4'h0, 3'b000));

        // All-zero responses: 0..14 twenty times then 15, 301 errors.
        drive(1'b1, 1'b1, 1'b0, 4'h0, 3'b000);
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 15; i++) drive(1'b1, 1'b0, 1'b1, 4'(i), 3'b000);
        end
        drive(1'b1, 1'b0, 1'b1, 4'hF, 3'b000);
        drive_hand(mk_exp(0, 1, 0, 8'd255, 4'd15, 16'd301, 1, 4'h0, 3'b000));

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_comparator_2bit_checker
